stage_sequencer: RTL and testbench

//  Parametrised top-level controller for the subdivision pipeline: launches NUM_STAGES compute

---
 rtl/subsurf_pkg.sv | 15 +
 rtl/ram_port_mux.sv | 40 ++++
 rtl/stage_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_stage_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/subsurf_pkg.sv
// Shared types and default widths for the subdivision pipeline controller.
package subsurf_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPulse,
    StAck,
    StRun
  } seq_state_t;

  localparam int unsigned DefAddrWidth = 11;
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefWeWidth   = 4;

endpackage

// File: rtl/ram_port_mux.sv
// Routes one stage's RAM port bundle onto the shared ports; drives zero when no stage is selected.
module ram_port_mux #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned NUM_PORTS  = 3,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WE_WIDTH   = 4,
  parameter int unsigned SEL_W      = 2
) (
  input  logic                                          sel_valid_i,
  input  logic [SEL_W-1:0]                              sel_i,
  input  logic [NUM_STAGES*NUM_PORTS-1:0]               s_en_i,
  input  logic [NUM_STAGES*NUM_PORTS*ADDR_WIDTH-1:0]    s_a_i,
  input  logic [NUM_STAGES*NUM_PORTS*WE_WIDTH-1:0]      s_we_i,
  input  logic [NUM_STAGES*NUM_PORTS*DATA_WIDTH-1:0]    s_di_i,
  output logic [NUM_PORTS-1:0]                          en_o,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0]               a_o,
  output logic [NUM_PORTS*WE_WIDTH-1:0]                 we_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]               di_o
);

  // Select the active stage's bundle per port; at most one stage matches sel_i.
  always_comb begin
    en_o = '0;
    a_o  = '0;
    we_o = '0;
    di_o = '0;
    for (int s = 0; s < int'(NUM_STAGES); s++) begin
      if (sel_valid_i && (sel_i == SEL_W'(s))) begin
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
          en_o[p]                          = s_en_i[s*NUM_PORTS+p];
          a_o[p*ADDR_WIDTH +: ADDR_WIDTH]  = s_a_i[(s*NUM_PORTS+p)*ADDR_WIDTH +: ADDR_WIDTH];
          we_o[p*WE_WIDTH +: WE_WIDTH]     = s_we_i[(s*NUM_PORTS+p)*WE_WIDTH +: WE_WIDTH];
          di_o[p*DATA_WIDTH +: DATA_WIDTH] = s_di_i[(s*NUM_PORTS+p)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Launches the pipeline stages in order for a number of levels, muxes the active stage onto the
// shared RAM ports and reports done / ack-timeout error.
module stage_sequencer
  import subsurf_pkg::*;
#(
  parameter int unsigned NUM_STAGES   = 3,
  parameter int unsigned NUM_PORTS    = 3,
  parameter int unsigned ADDR_WIDTH   = DefAddrWidth,
  parameter int unsigned DATA_WIDTH   = DefDataWidth,
  parameter int unsigned WE_WIDTH     = DefWeWidth,
  parameter int unsigned LVL_W        = 4,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned ACK_TIMEOUT  = 64
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   start_i,
  input  logic [LVL_W-1:0]                                       levels_i,
  input  logic                                                   abort_i,
  input  logic [NUM_STAGES-1:0]                                  stage_busy_i,
  output logic [NUM_STAGES-1:0]                                  stage_start_o,
  input  logic [NUM_STAGES*NUM_PORTS-1:0]                        s_en_i,
  input  logic [NUM_STAGES*NUM_PORTS*ADDR_WIDTH-1:0]             s_a_i,
  input  logic [NUM_STAGES*NUM_PORTS*WE_WIDTH-1:0]               s_we_i,
  input  logic [NUM_STAGES*NUM_PORTS*DATA_WIDTH-1:0]             s_di_i,
  output logic [NUM_PORTS-1:0]                                   en_o,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0]                        a_o,
  output logic [NUM_PORTS*WE_WIDTH-1:0]                          we_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]                        di_o,
  output logic                                                   busy_o,
  output logic                                                   done_o,
  output logic                                                   error_o,
  output logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] cur_stage_o,
  output logic [LVL_W-1:0]                                       cur_level_o
);

  localparam int unsigned StageW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int unsigned CntMax = (START_CYCLES > ACK_TIMEOUT) ? START_CYCLES : ACK_TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0]   PulseLast = CntW'(START_CYCLES - 1);
  localparam logic [CntW-1:0]   AckLast   = CntW'(ACK_TIMEOUT - 1);
  localparam logic [StageW-1:0] LastStage = StageW'(NUM_STAGES - 1);

  seq_state_t            state_q, state_d;
  logic [StageW-1:0]     stage_q, stage_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [LVL_W-1:0]      levels_q, levels_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  busy_seen_q, busy_seen_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [NUM_STAGES-1:0] stage_start_q, stage_start_d;

  logic cur_busy, accept, empty_start, last_stage, last_level;

  assign cur_busy    = stage_busy_i[stage_q];
  assign accept      = start_i & ~abort_i & (levels_i != '0);
  assign empty_start = start_i & ~abort_i & (levels_i == '0);
  assign last_stage  = (stage_q == LastStage);
  // levels_q is never zero while a run is active, so the subtraction cannot wrap.
  assign last_level  = !(level_q < (levels_q - LVL_W'(1)));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic; abort takes priority over completion and timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StPulse;
      StPulse: begin
        if (abort_i)                 state_d = StIdle;
        else if (cnt_q == PulseLast) state_d = (busy_seen_q | cur_busy) ? StRun : StAck;
      end
      StAck: begin
        if (abort_i)               state_d = StIdle;
        else if (cur_busy)         state_d = StRun;
        else if (cnt_q == AckLast) state_d = StIdle;
      end
      StRun: begin
        if (abort_i)        state_d = StIdle;
        else if (!cur_busy) state_d = (last_stage && last_level) ? StIdle : StPulse;
      end
      default: state_d = StIdle;
    endcase
  end

  // Next values of counters, indices and registered outputs.
  always_comb begin
    stage_d       = stage_q;
    level_d       = level_q;
    levels_d      = levels_q;
    cnt_d         = cnt_q;
    busy_seen_d   = busy_seen_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    error_d       = error_q;
    stage_start_d = stage_start_q;
    unique case (state_q)
      StIdle: begin
        if (empty_start) begin
          done_d  = 1'b1;
          error_d = 1'b0;
        end else if (accept) begin
          levels_d      = levels_i;
          stage_d       = '0;
          level_d       = '0;
          busy_d        = 1'b1;
          error_d       = 1'b0;
          cnt_d         = '0;
          busy_seen_d   = 1'b0;
          stage_start_d = NUM_STAGES'(1);
        end
      end
      StPulse: begin
        if (abort_i) begin
          busy_d        = 1'b0;
          stage_start_d = '0;
        end else begin
          busy_seen_d = busy_seen_q | cur_busy;
          cnt_d       = cnt_q + CntW'(1);
          if (cnt_q == PulseLast) begin
            stage_start_d = '0;
            cnt_d         = '0;
          end
        end
      end
      StAck: begin
        if (abort_i) begin
          busy_d = 1'b0;
        end else if (!cur_busy) begin
          if (cnt_q == AckLast) begin
            busy_d  = 1'b0;
            error_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StRun: begin
        if (abort_i) begin
          busy_d = 1'b0;
        end else if (!cur_busy) begin
          if (last_stage && last_level) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            if (!last_stage) begin
              stage_d = stage_q + StageW'(1);
            end else begin
              stage_d = '0;
              level_d = level_q + LVL_W'(1);
            end
            cnt_d                  = '0;
            busy_seen_d            = 1'b0;
            stage_start_d          = '0;
            stage_start_d[stage_d] = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q       <= '0;
      level_q       <= '0;
      levels_q      <= '0;
      cnt_q         <= '0;
      busy_seen_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      stage_start_q <= '0;
    end else begin
      stage_q       <= stage_d;
      level_q       <= level_d;
      levels_q      <= levels_d;
      cnt_q         <= cnt_d;
      busy_seen_q   <= busy_seen_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      stage_start_q <= stage_start_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign stage_start_o = stage_start_q;
  assign cur_stage_o   = stage_q;
  assign cur_level_o   = level_q;

  ram_port_mux #(
    .NUM_STAGES (NUM_STAGES),
    .NUM_PORTS  (NUM_PORTS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .WE_WIDTH   (WE_WIDTH),
    .SEL_W      (StageW)
  ) u_mux (
    .sel_valid_i (state_q != StIdle),
    .sel_i       (stage_q),
    .s_en_i      (s_en_i),
    .s_a_i       (s_a_i),
    .s_we_i      (s_we_i),
    .s_di_i      (s_di_i),
    .en_o        (en_o),
    .a_o         (a_o),
    .we_o        (we_o),
    .di_o        (di_o)
  );

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboarded bench: stage-start / done events are queued by the stimulus and popped by a monitor.
module tb_stage_sequencer;

  localparam int NS = 3, NP = 3, AW = 11, DW = 32, WW = 4, LW = 4, SW = 2, TMO = 16;

  logic               clk, rst_n, start_i, abort_i;
  logic [LW-1:0]      levels_i;
  logic [NS-1:0]      stage_busy_i, stage_start_o;
  logic [NS*NP-1:0]   s_en_i;
  logic [NS*NP*AW-1:0] s_a_i;
  logic [NS*NP*WW-1:0] s_we_i;
  logic [NS*NP*DW-1:0] s_di_i;
  logic [NP-1:0]      en_o;
  logic [NP*AW-1:0]   a_o;
  logic [NP*WW-1:0]   we_o;
  logic [NP*DW-1:0]   di_o;
  logic               busy_o, done_o, error_o;
  logic [SW-1:0]      cur_stage_o;
  logic [LW-1:0]      cur_level_o;

  stage_sequencer #(
    .NUM_STAGES(NS), .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW),
    .LVL_W(LW), .START_CYCLES(2), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .levels_i(levels_i), .abort_i(abort_i),
    .stage_busy_i(stage_busy_i), .stage_start_o(stage_start_o), .s_en_i(s_en_i),
    .s_a_i(s_a_i), .s_we_i(s_we_i), .s_di_i(s_di_i), .en_o(en_o), .a_o(a_o), .we_o(we_o),
    .di_o(di_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .cur_stage_o(cur_stage_o), .cur_level_o(cur_level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int exp_q[$];
  int mode[NS];       // 0: busy 10 cycles after start falls, 1: never busy, 2: busy 1 cycle in pulse
  int remain[NS];
  bit pending[NS];
  int fall_cyc[NS];
  int rise_cyc[NS];
  bit lat_chk = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic pop_cmp(input string name, input int code);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: unexpected event %0d, expected none", name, code);
    end else begin
      check(name, code, exp_q.pop_front());
    end
  endtask

  function automatic logic [AW-1:0] f_a(input int s, input int p);
    if (s == 1 && p == 0) return 11'h155;
    return AW'(s * 16 + p + 1);
  endfunction
  function automatic logic [WW-1:0] f_we(input int s, input int p);
    if (s == 1 && p == 0) return 4'hF;
    return WW'(s + p + 1);
  endfunction
  function automatic logic [DW-1:0] f_di(input int s, input int p);
    return 32'hA000_0000 + DW'(s * 256 + p);
  endfunction

  // Stage models, driven on the falling edge.
  initial begin
    logic [NS-1:0] prev;
    prev = '0;
    stage_busy_i = '0;
    for (int s = 0; s < NS; s++) begin
      remain[s] = 0; pending[s] = 0; mode[s] = 0; fall_cyc[s] = 0;
    end
    forever begin
      @(negedge clk);
      for (int s = 0; s < NS; s++) begin
        if (stage_start_o[s] === 1'b1 && !prev[s]) begin
          if (mode[s] == 0) pending[s] = 1;
          else if (mode[s] == 2) remain[s] = 1;
        end
        if (pending[s] && stage_start_o[s] === 1'b0) begin
          pending[s] = 0;
          remain[s]  = 10;
        end
        if (remain[s] > 0) begin
          stage_busy_i[s] = 1'b1;
          remain[s]--;
        end else begin
          if (stage_busy_i[s]) fall_cyc[s] = cyc;
          stage_busy_i[s] = 1'b0;
        end
        prev[s] = (stage_start_o[s] === 1'b1);
      end
    end
  end

  // Monitor: start events coded level*10+stage, done coded 99.
  initial begin
    logic [NS-1:0] prev;
    int len, idx;
    prev = '0; len = 0;
    forever begin
      @(negedge clk);
      if (stage_start_o != 0 && prev == 0) begin
        idx = 0;
        for (int s = 0; s < NS; s++) if (stage_start_o[s]) idx = s;
        rise_cyc[idx] = cyc;
        check("start_onehot", 64'($countones(stage_start_o)), 1);
        pop_cmp("start_event", int'(cur_level_o) * 10 + idx);
        len = 0;
      end
      if (stage_start_o != 0) len++;
      if (stage_start_o == 0 && prev != 0) check("start_len", 64'(len), 2);
      if (done_o === 1'b1) begin
        pop_cmp("done_event", 99);
        if (lat_chk) check("done_latency", 64'(cyc - fall_cyc[NS-1]), 1);
      end
      prev = (stage_start_o === 'x) ? '0 : stage_start_o;
    end
  end

  task automatic do_start(input int lv);
    levels_i = LW'(lv);
    start_i  = 1'b1;
    @(negedge clk);
    start_i  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (busy_o && i < 300) begin
      @(negedge clk);
      i++;
    end
    n_checks++;
    if (!busy_o) n_pass++;
    else $display("FAIL %s: busy still 1 after %0d cycles, required 0", name, i);
  endtask

  task automatic wait_ss(input int s, input logic val, input string name);
    int i;
    i = 0;
    while (stage_start_o[s] !== val && i < 300) begin
      @(negedge clk);
      i++;
    end
    n_checks++;
    if (stage_start_o[s] === val) n_pass++;
    else $display("FAIL %s: stage_start[%0d] never reached %b", name, s, val);
  endtask

  task automatic wait_stage(input int s, input string name);
    int i;
    i = 0;
    while (cur_stage_o !== SW'(s) && i < 300) begin
      @(negedge clk);
      i++;
    end
    check(name, 64'(cur_stage_o), 64'(s));
  endtask

  task automatic drain(input string name);
    repeat (15) @(negedge clk);
    check(name, 64'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; levels_i = '0;
    for (int s = 0; s < NS; s++) begin
      for (int p = 0; p < NP; p++) begin
        s_en_i[s*NP+p]         = !(s == 2 && p == 1);
        s_a_i[(s*NP+p)*AW +: AW] = f_a(s, p);
        s_we_i[(s*NP+p)*WW +: WW] = f_we(s, p);
        s_di_i[(s*NP+p)*DW +: DW] = f_di(s, p);
      end
    end
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy_o), 0);
    check("rst_done", 64'(done_o), 0);
    check("rst_error", 64'(error_o), 0);
    check("rst_stage_start", 64'(stage_start_o), 0);
    check("rst_cur_stage", 64'(cur_stage_o), 0);
    check("rst_cur_level", 64'(cur_level_o), 0);
    check("rst_ports", 64'(en_o) | 64'(a_o) | 64'(we_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single level, three stages in order.
    lat_chk = 1;
    exp_q = '{0, 1, 2, 99};
    do_start(1);
    check("t1_busy_after_start", 64'(busy_o), 1);
    wait_idle("t1_idle");
    check("t1_error", 64'(error_o), 0);
    drain("t1_drained");

    // 2: two levels.
    exp_q = '{0, 1, 2, 10, 11, 12, 99};
    do_start(2);
    wait_idle("t2_idle");
    drain("t2_drained");

    // 3: stage 1 never acknowledges -> timeout after TMO ACK cycles.
    lat_chk = 0;
    mode[1] = 1;
    exp_q = '{0, 1};
    do_start(1);
    wait_ss(1, 1'b1, "t3_ss1_rise");
    wait_ss(1, 1'b0, "t3_ss1_fall");
    c0 = cyc;
    wait_idle("t3_idle");
    check("t3_ack_cycles", 64'(cyc - c0), TMO);
    check("t3_error", 64'(error_o), 1);
    drain("t3_drained");
    check("t3_error_sticky", 64'(error_o), 1);
    mode[1] = 0;
    lat_chk = 1;
    exp_q = '{0, 1, 2, 99};
    do_start(1);
    check("t3_error_cleared", 64'(error_o), 0);
    wait_idle("t3b_idle");
    drain("t3b_drained");

    // 4: abort three cycles into stage 1 RUN.
    exp_q = '{0, 1};
    do_start(1);
    wait_ss(1, 1'b1, "t4_ss1_rise");
    wait_ss(1, 1'b0, "t4_ss1_fall");
    repeat (4) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("t4_busy", 64'(busy_o), 0);
    check("t4_stage_start", 64'(stage_start_o), 0);
    check("t4_ports", 64'(en_o) | 64'(a_o) | 64'(we_o), 0);
    check("t4_error", 64'(error_o), 0);
    drain("t4_drained");

    // 5: port mux follows cur_stage, zero in IDLE.
    exp_q = '{0, 1, 2, 99};
    do_start(1);
    check("t5_s0_a0", 64'(a_o[AW-1:0]), 64'h001);
    check("t5_s0_en", 64'(en_o), 64'b111);
    wait_stage(1, "t5_reach_s1");
    check("t5_s1_a0", 64'(a_o[AW-1:0]), 64'h155);
    check("t5_s1_we0", 64'(we_o[WW-1:0]), 64'hF);
    check("t5_s1_en0", 64'(en_o[0]), 1);
    check("t5_s1_di0", 64'(di_o[DW-1:0]), 64'hA000_0100);
    check("t5_s1_a2", 64'(a_o[2*AW +: AW]), 64'h013);
    check("t5_s1_we2", 64'(we_o[2*WW +: WW]), 64'h4);
    wait_stage(2, "t5_reach_s2");
    check("t5_s2_en", 64'(en_o), 64'b101);
    check("t5_s2_di1", 64'(di_o[DW +: DW]), 64'hA000_0201);
    wait_idle("t5_idle");
    check("t5_idle_ports", 64'(en_o) | 64'(a_o) | 64'(we_o) | 64'(di_o[63:0]), 0);
    drain("t5_drained");

    // 6a: levels=0 completes immediately.
    lat_chk = 0;
    exp_q = '{99};
    do_start(0);
    check("t6_busy", 64'(busy_o), 0);
    drain("t6a_drained");

    // 6b: busy seen inside PULSE skips ACK; stage 1 starts three cycles after stage 0.
    mode[0] = 2;
    lat_chk = 1;
    exp_q = '{0, 1, 2, 99};
    do_start(1);
    wait_idle("t6b_idle");
    check("t6b_skip_ack", 64'(rise_cyc[1] - rise_cyc[0]), 3);
    check("t6b_error", 64'(error_o), 0);
    drain("t6b_drained");
    mode[0] = 0;

    // 7: reset mid-run clears everything at once.
    lat_chk = 0;
    exp_q = '{0};
    do_start(1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t7_busy", 64'(busy_o), 0);
    check("t7_ports", 64'(en_o) | 64'(a_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drain("t7_drained");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
